// File: rtl/fact_ctrl.sv
// Sequencing FSM for the iterative factorial datapath (init / compare / inc / mul).
// Optional iteration watchdog with ERR state: define FACT_CTRL_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for go; all outputs low
// INIT  | load counter and product register with 1
// CHECK | sample proceed; choose next iteration or finish
// INC   | increment datapath counter
// MUL   | product := product * counter
// DONE  | result valid; hold until go drops
// ERR   | watchdog abort (watchdog builds only); hold until go drops
module fact_ctrl #(
  parameter int SIZE     = 8,
  parameter int MAX_ITER = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  input  logic proceed_i,
  output logic sel_init_o,
  output logic cnt_load_o,
  output logic cnt_en_o,
  output logic reg_load_o,
  output logic done_o,
  output logic busy_o,
  output logic err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_INC   = 3'd3,
    S_MUL   = 3'd4,
    S_DONE  = 3'd5
`ifdef FACT_CTRL_WATCHDOG_EN
    , S_ERR = 3'd6
`endif
  } state_e;

  localparam logic [SIZE-1:0] ITER_LIMIT = SIZE'(MAX_ITER);

  state_e          state_q, state_d;
  logic [SIZE-1:0] iter_q, iter_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE:  if (go_i) state_d = S_INIT;
      S_INIT: begin
        iter_d  = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!proceed_i)                  state_d = S_DONE;
`ifdef FACT_CTRL_WATCHDOG_EN
        else if (iter_q == ITER_LIMIT)   state_d = S_ERR;
`endif
        else                             state_d = S_INC;
      end
      S_INC: begin
        // saturate so a long run cannot wrap past the watchdog limit
        if (iter_q != '1) iter_d = iter_q + 1'b1;
        state_d = S_MUL;
      end
      S_MUL:   state_d = S_CHECK;
      S_DONE:  if (!go_i) state_d = S_IDLE;
`ifdef FACT_CTRL_WATCHDOG_EN
      S_ERR:   if (!go_i) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_init_o = 1'b0;
    cnt_load_o = 1'b0;
    cnt_en_o   = 1'b0;
    reg_load_o = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    busy_o     = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        sel_init_o = 1'b1;
        cnt_load_o = 1'b1;
        reg_load_o = 1'b1;
      end
      S_INC:  cnt_en_o   = 1'b1;
      S_MUL:  reg_load_o = 1'b1;
      S_DONE: done_o     = 1'b1;
`ifdef FACT_CTRL_WATCHDOG_EN
      S_ERR:  err_o      = 1'b1;
`endif
      default: ;
    endcase
  end

`ifndef FACT_CTRL_WATCHDOG_EN
  // iteration count has no consumer without the watchdog
  logic unused_cfg;
  assign unused_cfg = ^{iter_q, ITER_LIMIT};
`endif

endmodule
